// File: rtl/i2c_slave_regfile.sv
// i2c_slave_regfile: I2C target with a byte-addressed register file, bus oversampled on i_clk
// Ports: i_clk system clock (>= 8x SCL), i_rst_n async active-low reset, i_scl bus clock,
//        io_sda open-drain data (driven 0 or z), o_wr_valid/o_wr_addr/o_wr_data commit pulse,
//        o_busy high from START until STOP or master NACK.
module i2c_slave_regfile #(
  parameter logic [6:0] SLAVE_ADDR = 7'h41,
  parameter int         DEPTH      = 16,
  parameter logic [7:0] RST_VAL    = 8'h00
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_scl,
  inout  wire        io_sda,
  output logic       o_wr_valid,
  output logic [7:0] o_wr_addr,
  output logic [7:0] o_wr_data,
  output logic       o_busy
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] IDLE = 4'd0, ADDR = 4'd1, ADDR_ACK = 4'd2, REG = 4'd3, REG_ACK = 4'd4,
                         WDATA = 4'd5, WDATA_ACK = 4'd6, RDATA = 4'd7, RACK = 4'd8, WAIT = 4'd9;
  logic [1:0] r_scl_s, r_sda_s;
  logic       r_scl_d, r_sda_d;
  logic [3:0] r_state, r_cnt;
  logic [7:0] r_shift, r_ptr;
  logic       r_sda_oe, r_rw;
  logic [7:0] r_regs [DEPTH];
  logic       w_scl, w_sda, w_rise, w_fall, w_start, w_stop;
  logic [7:0] w_byte, w_rd;
  logic [AW-1:0] w_idx;
  assign io_sda  = r_sda_oe ? 1'b0 : 1'bz;
  assign w_scl   = r_scl_s[1];
  assign w_sda   = r_sda_s[1];
  assign w_rise  = w_scl & ~r_scl_d;
  assign w_fall  = ~w_scl & r_scl_d;
  // SDA edges only count as START/STOP while SCL is stable high
  assign w_start = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop  = w_scl & r_scl_d & ~r_sda_d & w_sda;
  assign w_byte  = {r_shift[6:0], w_sda};
  assign w_idx   = r_ptr[AW-1:0];
  assign w_rd    = r_regs[w_idx];
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_scl_s <= 2'b11;
      r_sda_s <= 2'b11;
      r_scl_d <= 1'b1;
      r_sda_d <= 1'b1;
    end else begin
      r_scl_s <= {r_scl_s[0], i_scl};
      r_sda_s <= {r_sda_s[0], io_sda};
      r_scl_d <= w_scl;
      r_sda_d <= w_sda;
    end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= 4'd0;
      r_shift    <= 8'd0;
      r_ptr      <= 8'd0;
      r_sda_oe   <= 1'b0;
      r_rw       <= 1'b0;
      o_wr_valid <= 1'b0;
      o_wr_addr  <= 8'd0;
      o_wr_data  <= 8'd0;
      o_busy     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= RST_VAL;
    end else begin
      o_wr_valid <= 1'b0;
      if (w_start) begin
        r_state  <= ADDR;
        r_cnt    <= 4'd0;
        r_sda_oe <= 1'b0;
        o_busy   <= 1'b1;
      end else if (w_stop) begin
        r_state  <= IDLE;
        r_sda_oe <= 1'b0;
        o_busy   <= 1'b0;
      end else if (w_rise) begin
        case (r_state)
          ADDR, REG, WDATA: begin
            r_shift <= w_byte;
            r_cnt   <= r_cnt + 4'd1;
            if (r_state == WDATA && r_cnt == 4'd7) begin
              r_regs[w_idx] <= w_byte;
              o_wr_valid    <= 1'b1;
              o_wr_addr     <= r_ptr;
              o_wr_data     <= w_byte;
            end
          end
          RDATA: r_cnt <= r_cnt + 4'd1;
          RACK: begin
            if (w_sda) begin
              r_state <= WAIT;
              o_busy  <= 1'b0;
            end else r_ptr <= r_ptr + 8'd1;
          end
          default: ;
        endcase
      end else if (w_fall) begin
        case (r_state)
          ADDR: if (r_cnt == 4'd8) begin
            if (r_shift[7:1] == SLAVE_ADDR) begin
              r_state  <= ADDR_ACK;
              r_sda_oe <= 1'b1;
              r_rw     <= r_shift[0];
            end else r_state <= WAIT;
          end
          REG: if (r_cnt == 4'd8) begin
            r_ptr    <= r_shift;
            r_state  <= REG_ACK;
            r_sda_oe <= 1'b1;
          end
          WDATA: if (r_cnt == 4'd8) begin
            r_state  <= WDATA_ACK;
            r_sda_oe <= 1'b1;
          end
          ADDR_ACK: begin
            r_cnt    <= 4'd0;
            r_state  <= r_rw ? RDATA : REG;
            r_shift  <= w_rd;
            r_sda_oe <= r_rw & ~w_rd[7];
          end
          REG_ACK, WDATA_ACK: begin
            r_cnt    <= 4'd0;
            r_state  <= WDATA;
            r_sda_oe <= 1'b0;
            r_ptr    <= r_state == WDATA_ACK ? r_ptr + 8'd1 : r_ptr;
          end
          RDATA: begin
            if (r_cnt == 4'd8) begin
              r_sda_oe <= 1'b0;
              r_state  <= RACK;
            end else begin
              r_shift  <= r_shift << 1;
              r_sda_oe <= ~r_shift[6];
            end
          end
          // master ACKed: pointer already advanced at the SCL rise, reload and keep sending
          RACK: begin
            r_cnt    <= 4'd0;
            r_state  <= RDATA;
            r_shift  <= w_rd;
            r_sda_oe <= ~w_rd[7];
          end
          default: ;
        endcase
      end
    end
endmodule
